// File: rtl/riscv_v_rf_wb_scoreboard.sv
// riscv_v_rf_wb_scoreboard: vector RF writeback storage, two combinational ID read ports, per-register RAW scoreboard.
// Define RISCV_V_RF_BYPASS_EN to enable the WB->ID byte-wise bypass.
module riscv_v_rf_wb_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int VLEN      = 128,
    parameter int ID2WB_LAT = 3,
    localparam int AW = $clog2(NUM_REGS),
    localparam int BE = VLEN / 8,
    localparam int CW = $clog2(ID2WB_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            issue_valid_id,
    input  logic [AW-1:0]   issue_addr_id,
    input  logic [AW-1:0]   rd_addr_srca_id,
    input  logic [AW-1:0]   rd_addr_srcb_id,
    output logic [VLEN-1:0] rd_data_srca_id,
    output logic [VLEN-1:0] rd_data_srcb_id,
    output logic            hazard_stall,
    input  logic [AW-1:0]   rf_wr_addr_wb,
    input  logic [BE-1:0]   rf_wr_en_wb,
    input  logic [VLEN-1:0] rf_wr_data_wb,
    input  logic            retire_valid_wb
);
    logic [VLEN-1:0]     mem [NUM_REGS];
    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc, dec;
    logic [VLEN-1:0]     wr_mask;
    logic                pend_a, pend_b;

    for (genvar b = 0; b < BE; b++) begin : g_mask
        assign wr_mask[8*b +: 8] = {8{rf_wr_en_wb[b]}};
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc[r] = issue_valid_id & ~stall & ~hazard_stall & ~flush & (issue_addr_id == AW'(r));
        assign dec[r] = retire_valid_wb & ~stall & (rf_wr_addr_wb == AW'(r));
    end

    always_ff @(posedge clk) begin
        if (!stall)
            mem[rf_wr_addr_wb] <= (mem[rf_wr_addr_wb] & ~wr_mask) | (rf_wr_data_wb & wr_mask);
    end

    // Flush drops every in-flight count; the WB write in that cycle still commits above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + CW'(1);
                else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CW'(1);
        end
    end

`ifdef RISCV_V_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
    assign rd_data_srca_id = (~stall && rf_wr_addr_wb == rd_addr_srca_id)
        ? (mem[rd_addr_srca_id] & ~wr_mask) | (rf_wr_data_wb & wr_mask) : mem[rd_addr_srca_id];
    assign rd_data_srcb_id = (~stall && rf_wr_addr_wb == rd_addr_srcb_id)
        ? (mem[rd_addr_srcb_id] & ~wr_mask) | (rf_wr_data_wb & wr_mask) : mem[rd_addr_srcb_id];
`else
    localparam bit BYP = 1'b0;
    assign rd_data_srca_id = mem[rd_addr_srca_id];
    assign rd_data_srcb_id = mem[rd_addr_srcb_id];
`endif

    // A same-cycle retire only clears the hazard when its data is bypassed.
    assign pend_a       = (cnt[rd_addr_srca_id] != '0) & ~(BYP & dec[rd_addr_srca_id]);
    assign pend_b       = (cnt[rd_addr_srcb_id] != '0) & ~(BYP & dec[rd_addr_srcb_id]);
    assign hazard_stall = ~flush & (pend_a | pend_b);

    always @(posedge clk) begin
        if (!rst)
            for (int r = 0; r < NUM_REGS; r++) begin
                assert (!(inc[r] && cnt[r] == CW'(ID2WB_LAT)));
                assert (!(dec[r] && cnt[r] == '0));
            end
    end
endmodule

// File: tb/tb_riscv_v_rf_wb_scoreboard.sv
// tb_riscv_v_rf_wb_scoreboard: directed checks of writes, reads, bypass and the RAW scoreboard.
module tb_riscv_v_rf_wb_scoreboard;
    localparam int VLEN = 128;
`ifdef RISCV_V_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [VLEN-1:0] ZERO = '0;
    localparam logic [VLEN-1:0] ONE  = VLEN'(1);
    localparam logic [VLEN-1:0] AA   = {16{8'hAA}};
    localparam logic [VLEN-1:0] V5O  = {16{8'h11}};
    localparam logic [VLEN-1:0] V5N  = {{12{8'h11}}, {4{8'hFF}}};
    localparam logic [VLEN-1:0] X5A  = {16{8'h5A}};
    localparam logic [VLEN-1:0] X33  = {16{8'h33}};

    logic            clk, rst, stall, flush, issue_valid_id, retire_valid_wb, hazard_stall;
    logic [4:0]      issue_addr_id, rd_addr_srca_id, rd_addr_srcb_id, rf_wr_addr_wb;
    logic [15:0]     rf_wr_en_wb;
    logic [VLEN-1:0] rf_wr_data_wb, rd_data_srca_id, rd_data_srcb_id, hz;
    int              total = 0, passed = 0;

    assign hz = VLEN'(hazard_stall);

    riscv_v_rf_wb_scoreboard dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .issue_valid_id(issue_valid_id), .issue_addr_id(issue_addr_id),
        .rd_addr_srca_id(rd_addr_srca_id), .rd_addr_srcb_id(rd_addr_srcb_id),
        .rd_data_srca_id(rd_data_srca_id), .rd_data_srcb_id(rd_data_srcb_id),
        .hazard_stall(hazard_stall), .rf_wr_addr_wb(rf_wr_addr_wb),
        .rf_wr_en_wb(rf_wr_en_wb), .rf_wr_data_wb(rf_wr_data_wb),
        .retire_valid_wb(retire_valid_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        stall = 0; flush = 0; issue_valid_id = 0; issue_addr_id = 0; retire_valid_wb = 0;
        rd_addr_srca_id = 0; rd_addr_srcb_id = 0; rf_wr_addr_wb = 0; rf_wr_en_wb = 0; rf_wr_data_wb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [VLEN-1:0] d);
        idle(); rf_wr_addr_wb = a; rf_wr_en_wb = '1; rf_wr_data_wb = d;
        tick();
    endtask

    initial begin
        rst = 1; idle();
        #1 check("rst_hz", hz, ZERO);
        tick(); tick(); rst = 0;
        // plain write then read through storage
        wr(5'd3, AA);
        idle(); rd_addr_srca_id = 3;
        #1 check("v3_rd", rd_data_srca_id, AA);
        wr(5'd5, V5O);
        wr(5'd6, ZERO);
        // partial-byte write with same-cycle read
        idle(); rf_wr_addr_wb = 5; rf_wr_en_wb = 16'h000F; rf_wr_data_wb = '1; rd_addr_srcb_id = 5;
        #1 check("v5_byp", rd_data_srcb_id, BYP ? V5N : V5O);
        tick();
        idle(); rd_addr_srcb_id = 5;
        #1 check("v5_merged", rd_data_srcb_id, V5N);
        // RAW on v7: issue cyc0, retire cyc3
        idle(); issue_valid_id = 1; issue_addr_id = 7; rd_addr_srca_id = 7;
        #1 check("v7_self", hz, ZERO);
        tick();
        idle(); rd_addr_srca_id = 7;
        #1 check("v7_c1", hz, ONE);
        tick();
        idle(); rd_addr_srcb_id = 7;
        #1 check("v7_c2_srcb", hz, ONE);
        tick();
        idle(); rd_addr_srca_id = 7; retire_valid_wb = 1; rf_wr_addr_wb = 7;
        #1 check("v7_c3", hz, BYP ? ZERO : ONE);
        tick();
        idle(); rd_addr_srca_id = 7;
        #1 check("v7_c4", hz, ZERO);
        // flush clears v1/v2 pending; issue in flush cycle dropped; WB write commits
        idle(); issue_valid_id = 1; issue_addr_id = 1; tick();
        issue_addr_id = 2; tick();
        idle(); rd_addr_srca_id = 1; rd_addr_srcb_id = 2;
        #1 check("pend_v1v2", hz, ONE);
        flush = 1; issue_valid_id = 1; issue_addr_id = 9;
        rf_wr_addr_wb = 10; rf_wr_en_wb = '1; rf_wr_data_wb = X5A;
        #1 check("flush_hz", hz, ZERO);
        tick();
        idle(); rd_addr_srca_id = 1; rd_addr_srcb_id = 2;
        #1 check("post_flush", hz, ZERO);
        rd_addr_srca_id = 9; rd_addr_srcb_id = 0;
        #1 check("flush_issue", hz, ZERO);
        rd_addr_srca_id = 10;
        #1 check("flush_wr", rd_data_srca_id, X5A);
        // retire v6 held under stall for 2 cycles
        idle(); issue_valid_id = 1; issue_addr_id = 6; tick();
        idle(); stall = 1; retire_valid_wb = 1; rf_wr_addr_wb = 6; rf_wr_en_wb = '1;
        rf_wr_data_wb = X33; rd_addr_srca_id = 6;
        #1 check("stall_hz0", hz, ONE);
        check("stall_rd0", rd_data_srca_id, ZERO);
        tick();
        #1 check("stall_hz1", hz, ONE);
        check("stall_rd1", rd_data_srca_id, ZERO);
        tick();
        stall = 0;
        #1 check("unstall_hz", hz, BYP ? ZERO : ONE);
        check("unstall_rd", rd_data_srca_id, BYP ? X33 : ZERO);
        tick();
        idle(); rd_addr_srca_id = 6;
        #1 check("retired_hz", hz, ZERO);
        check("retired_rd", rd_data_srca_id, X33);
        tick();
        #1 check("no_underflow", hz, ZERO);
        // issue under stall is not counted
        idle(); stall = 1; issue_valid_id = 1; issue_addr_id = 8; tick();
        idle(); rd_addr_srca_id = 8;
        #1 check("stall_issue", hz, ZERO);
        // async reset with cnt[4]=2
        idle(); issue_valid_id = 1; issue_addr_id = 4; tick(); tick();
        idle(); rd_addr_srca_id = 4;
        #1 check("v4_pend", hz, ONE);
        #2 rst = 1;
        #1 check("async_rst", hz, ZERO);
        tick(); rst = 0;
        #1 check("v4_after_rst", hz, ZERO);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
